// File: rtl/host_mem_avmm_rd_engine.sv
// host_mem_avmm_rd_engine
// Avalon-MM burst read traffic engine for one host-memory channel. Issues a
// programmed sequence of line-addressed read bursts under an outstanding-line
// credit limit, XOR-folds the returned data into a 64-bit checksum and reports
// completion and run length.
// Optional feature macro: HOST_MEM_RD_ENGINE_STATS_EN adds o_max_outstanding,
// the peak number of outstanding lines seen during the last run.

module host_mem_avmm_rd_engine #(
    parameter int ADDR_WIDTH      = 42,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int MAX_OUTSTANDING = 256
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_base_addr,
    input  logic [31:0]                i_num_bursts,
    input  logic [BURST_CNT_WIDTH-1:0] i_burst_len,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [63:0]                o_checksum,
    output logic [31:0]                o_cycles,
    output logic [ADDR_WIDTH-1:0]      o_avmm_address,
    output logic                       o_avmm_read,
    output logic [BURST_CNT_WIDTH-1:0] o_avmm_burstcount,
    input  logic                       i_avmm_waitrequest,
    input  logic [DATA_WIDTH-1:0]      i_avmm_readdata,
    input  logic                       i_avmm_readdatavalid
`ifdef HOST_MEM_RD_ENGINE_STATS_EN
    ,
    output logic [15:0]                o_max_outstanding
`endif
);

    localparam int MAX_BURST = 1 << (BURST_CNT_WIDTH - 1);
    localparam int LANES     = DATA_WIDTH / 64;
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [31:0]                MAX_OUT_32  = 32'(MAX_OUTSTANDING);
    localparam logic [BURST_CNT_WIDTH-1:0] MAX_BURST_L = BURST_CNT_WIDTH'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                     r_state;
    logic [BURST_CNT_WIDTH-1:0] r_len;
    logic [31:0]                r_bursts_left;
    logic [OUT_W-1:0]           r_outstanding;
    logic                       r_read;
    logic [ADDR_WIDTH-1:0]      r_address;
    logic [BURST_CNT_WIDTH-1:0] r_burstcount;
    logic                       r_busy;
    logic                       r_done;
    logic [63:0]                r_checksum;
    logic [31:0]                r_cycles;

    logic [BURST_CNT_WIDTH-1:0] w_clamp_len;
    logic                       w_accept;
    logic                       w_beat;
    logic                       w_launch;
    logic [31:0]                w_out_ext;
    logic [31:0]                w_len_ext;
    logic [31:0]                w_commit;
    logic                       w_credit_ok;
    logic [OUT_W-1:0]           w_out_next;
    logic [63:0]                w_lane_acc [LANES+1];

    // Effective burst length: zero means one line, oversize saturates at the legal maximum
    always_comb begin
        if (i_burst_len == '0) begin
            w_clamp_len = BURST_CNT_WIDTH'(1);
        end else if (i_burst_len > MAX_BURST_L) begin
            w_clamp_len = MAX_BURST_L;
        end else begin
            w_clamp_len = i_burst_len;
        end
    end

    assign w_launch  = (r_state == S_IDLE) && i_start;
    assign w_accept  = r_read && !i_avmm_waitrequest;
    // A beat with nothing outstanding is stray (e.g. left over from before a reset)
    assign w_beat    = i_avmm_readdatavalid && (r_outstanding != '0);
    assign w_out_ext = 32'(r_outstanding);
    assign w_len_ext = 32'(r_len);

    // Credit for the next request counts the burst being accepted this cycle but
    // not the beats returning this cycle; those free credit one cycle later.
    assign w_commit    = w_out_ext + (w_accept ? w_len_ext : 32'd0);
    assign w_credit_ok = (w_commit + w_len_ext) <= MAX_OUT_32;

    // Never exceeds MAX_OUTSTANDING, so OUT_W bits cannot overflow
    assign w_out_next = r_outstanding
                      + (w_accept ? OUT_W'(r_len) : OUT_W'(0))
                      - (w_beat ? OUT_W'(1) : OUT_W'(0));

    // XOR of all 64-bit lanes of the incoming line
    assign w_lane_acc[0] = 64'd0;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_fold
        assign w_lane_acc[gi+1] = w_lane_acc[gi] ^ i_avmm_readdata[gi*64 +: 64];
    end

    // Run control FSM with registered Avalon request and status outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_bursts_left <= '0;
            r_read        <= 1'b0;
            r_address     <= '0;
            r_burstcount  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len         <= w_clamp_len;
                        r_burstcount  <= w_clamp_len;
                        r_address     <= i_base_addr;
                        r_bursts_left <= i_num_bursts;
                        if (i_num_bursts == 32'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            // Nothing is outstanding in IDLE and L never exceeds the limit
                            r_busy  <= 1'b1;
                            r_read  <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        // r_address always points at the next burst to request
                        r_address     <= r_address + ADDR_WIDTH'(r_len);
                        r_bursts_left <= r_bursts_left - 32'd1;
                        if (r_bursts_left == 32'd1) begin
                            r_read  <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_read <= w_credit_ok;
                        end
                    end else if (!r_read) begin
                        // A pending request is held untouched; only an idle slot re-checks credit
                        r_read <= w_credit_ok;
                    end
                end
                S_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outstanding-line credit counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_next;
        end
    end

    // Checksum fold and saturating run-cycle counter, both cleared on launch
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_checksum <= '0;
            r_cycles   <= '0;
        end else if (w_launch) begin
            r_checksum <= '0;
            r_cycles   <= '0;
        end else begin
            if (w_beat) begin
                r_checksum <= r_checksum ^ w_lane_acc[LANES];
            end
            if (r_busy && (r_cycles != 32'hFFFF_FFFF)) begin
                r_cycles <= r_cycles + 32'd1;
            end
        end
    end

`ifdef HOST_MEM_RD_ENGINE_STATS_EN
    logic [15:0] r_max_outstanding;

    // Peak outstanding lines over the current run
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_max_outstanding <= '0;
        end else if (w_launch) begin
            r_max_outstanding <= '0;
        end else if ({16'd0, r_max_outstanding} < w_out_ext) begin
            r_max_outstanding <= w_out_ext[15:0];
        end
    end

    assign o_max_outstanding = r_max_outstanding;
`endif

    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_checksum        = r_checksum;
    assign o_cycles          = r_cycles;
    assign o_avmm_address    = r_address;
    assign o_avmm_read       = r_read;
    assign o_avmm_burstcount = r_burstcount;

endmodule
